// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between a bus master and the SRAM responder.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a single-port synchronous SRAM macro.
// Reads are issued in the address phase, writes in the final data cycle;
// a read that lands on a write's final cycle is deferred by one cycle.
//
// state   | meaning
// S_IDLE  | no data phase in progress
// S_WAIT  | inserted wait cycle, cnt_q counts down to the final cycle
// S_DATA  | final data-phase cycle (HREADYOUT high); writes hit the SRAM here
// S_DEFER | read lost the SRAM port to a write; read is issued now
// S_ERR1  | first ERROR cycle (HREADYOUT low)
// S_ERR2  | second ERROR cycle (HREADYOUT high)
module ahb_sram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_sram_slave_if.slave   bus,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [3:0]        sram_ben,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [31:0]       sram_din,
  input  logic [31:0]       sram_dout
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_DEFER, S_ERR1, S_ERR2} state_t;

  state_t            state_q, state_d;
  state_t            after_issue;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [1:0]        size_q;

  logic can_accept, accept, addr_err, collide;
  logic unused_htrans0;

  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    lane_mask = 4'b0001 << a;
      2'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // SEQ and NONSEQ are handled identically, so only HTRANS[1] matters.
  assign unused_htrans0 = bus.HTRANS[0];

  assign can_accept  = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept      = can_accept && bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign addr_err    = (bus.HADDR[31:ADDR_W] != '0) || (bus.HSIZE > 3'd2) ||
                       (bus.HSIZE == 3'd1 && bus.HADDR[0]) ||
                       (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00);
  assign collide     = (state_q == S_DATA) && write_q && !bus.HWRITE;
  assign after_issue = (WAIT_STATES > 0) ? S_WAIT : S_DATA;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DATA;
      end
      S_DEFER: begin
        state_d = after_issue;
        cnt_d   = 4'(WAIT_STATES);
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (accept) begin
          if (addr_err) begin
            state_d = S_ERR1;
          end else if (collide) begin
            state_d = S_DEFER;
          end else begin
            state_d = after_issue;
            cnt_d   = 4'(WAIT_STATES);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State register and address-phase capture; reset drops any pending write.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.HADDR[ADDR_W-1:0];
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE[1:0];
      end
    end
  end

  // Bus response and SRAM port drive; a write in its final cycle owns the port.
  always_comb begin
    bus.HREADYOUT = !(state_q inside {S_WAIT, S_DEFER, S_ERR1});
    bus.HRESP     = (state_q == S_ERR1 || state_q == S_ERR2) ? 2'b01 : 2'b00;
    bus.HRDATA    = (!HRESET && state_q == S_DATA && !write_q) ? sram_dout : 32'h0;
    sram_cen      = 1'b1;
    sram_wen      = 1'b1;
    sram_ben      = 4'b0000;
    sram_addr     = '0;
    sram_din      = 32'h0;
    if (!HRESET) begin
      if (state_q == S_DATA && write_q) begin
        sram_cen  = 1'b0;
        sram_wen  = 1'b0;
        sram_ben  = lane_mask(addr_q[1:0], size_q);
        sram_addr = addr_q[ADDR_W-1:2];
        sram_din  = bus.HWDATA;
      end else if (state_q == S_DEFER) begin
        sram_cen  = 1'b0;
        sram_ben  = 4'b1111;
        sram_addr = addr_q[ADDR_W-1:2];
      end else if (accept && !bus.HWRITE && !addr_err) begin
        sram_cen  = 1'b0;
        sram_ben  = 4'b1111;
        sram_addr = bus.HADDR[ADDR_W-1:2];
      end
    end
  end

endmodule
